// File: rtl/odd_parity_serial_tx_if.sv
// Parallel-load / serial-out bundle for odd_parity_serial_tx.
// The host drives D and LOAD; the transmitter returns the line and status.
interface odd_parity_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] D;
  logic              LOAD;
  logic              READY;
  logic              TX;
  logic              P;
  logic              BUSY;
  logic              DONE;

  modport master (
    output D, LOAD,
    input  READY, TX, P, BUSY, DONE
  );

  modport slave (
    input  D, LOAD,
    output READY, TX, P, BUSY, DONE
  );
endinterface

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial frame transmitter: start bit, data LSB-first, odd parity bit, stop bit.
// Every serial bit is held for CLKS_PER_BIT clocks; all outputs come straight from flops.
module odd_parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  odd_parity_serial_tx_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [DATA_W-1:0] word);
    return ~(^word);
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              p_q, p_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              accept_s;
  logic              bit_end_s;
  logic [DATA_W-1:0] shifted_s;

  // Next-state, next-line-level and status computation for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    p_d       = p_q;
    done_d    = 1'b0;
    accept_s  = bus.LOAD & ready_q;
    bit_end_s = (cyc_q == CYC_LAST);
    shifted_s = shreg_q >> 1;

    if (state_q != IDLE) begin
      cyc_d = bit_end_s ? '0 : cyc_q + CW'(1);
    end else begin
      cyc_d = '0;
    end

    // TX is computed one cycle early so the flop changes only at bit boundaries.
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = START;
          shreg_d = bus.D;
          p_d     = odd_parity(bus.D);
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          tx_d    = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shreg_d = shifted_s;
          if (bit_q == BIT_LAST) begin
            state_d = PARITY;
            bit_d   = '0;
            tx_d    = p_q;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = shifted_s[0];
          end
        end else begin
          tx_d = shreg_q[0];
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d    = p_q;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          done_d  = 1'b0;
        end
        tx_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Sequencer state and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      p_q     <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      p_q     <= p_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.TX    = tx_q;
  assign bus.P     = p_q;
  assign bus.DONE  = done_q;
  assign bus.READY = ready_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Bench for odd_parity_serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit,
// a frame-level reference model checked every cycle, plus directed frame scenarios.
module tb_odd_parity_serial_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  odd_parity_serial_tx_if #(.DATA_W(W)) if1 ();
  odd_parity_serial_tx_if #(.DATA_W(W)) if4 ();

  odd_parity_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut1 (.CLK(clk), .RST(rst), .bus(if1));
  odd_parity_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(4)) dut4 (.CLK(clk), .RST(rst), .bus(if4));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model, index 0 = 1 clock/bit instance, index 1 = 4 clocks/bit instance
  bit         m_busy [2];
  int         m_cnt  [2];
  logic [7:0] m_word [2];
  logic       m_p    [2];
  logic       m_done [2];

  typedef struct {
    logic [7:0] w;
    logic       p;
  } vec_t;

  function automatic int nper(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Frame bit j as it appears on the line: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
  function automatic logic [10:0] make_frame(input logic [7:0] w);
    return {1'b1, ~(^w), w, 1'b0};
  endfunction

  // Receiving checker: C=1 when data plus parity holds an even number of ones
  function automatic logic checker_c(input logic [10:0] f);
    return ~(^f[9:1]);
  endfunction

  function automatic logic get_load(input int i); return (i == 0) ? if1.LOAD : if4.LOAD; endfunction
  function automatic logic [7:0] get_d(input int i); return (i == 0) ? if1.D : if4.D; endfunction
  function automatic logic get_tx(input int i); return (i == 0) ? if1.TX : if4.TX; endfunction
  function automatic logic get_ready(input int i); return (i == 0) ? if1.READY : if4.READY; endfunction
  function automatic logic get_busy(input int i); return (i == 0) ? if1.BUSY : if4.BUSY; endfunction
  function automatic logic get_done(input int i); return (i == 0) ? if1.DONE : if4.DONE; endfunction
  function automatic logic get_p(input int i); return (i == 0) ? if1.P : if4.P; endfunction

  function automatic logic exp_tx(input int i);
    logic [10:0] f;
    if (!m_busy[i]) return 1'b1;
    f = make_frame(m_word[i]);
    return f[(m_cnt[i] - 1) / nper(i)];
  endfunction

  task automatic set_in(input int i, input logic ld, input logic [7:0] d);
    if (i == 0) begin
      if1.LOAD = ld;
      if1.D    = d;
    end else begin
      if4.LOAD = ld;
      if4.D    = d;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: m_cnt counts cycles since the accepting edge, 1 .. 11*N
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_p[i]    <= 1'b0;
        m_done[i] <= 1'b0;
      end else if (!m_busy[i]) begin
        m_done[i] <= 1'b0;
        if (get_load(i)) begin
          m_busy[i] <= 1'b1;
          m_cnt[i]  <= 1;
          m_word[i] <= get_d(i);
          m_p[i]    <= ~(^get_d(i));
        end
      end else if (m_cnt[i] == 11 * nper(i)) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b1;
        m_cnt[i]  <= 0;
      end else begin
        m_cnt[i]  <= m_cnt[i] + 1;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mon_tx_n%0d", nper(i)), 32'(get_tx(i)), 32'(exp_tx(i)));
        chk($sformatf("mon_ready_n%0d", nper(i)), 32'(get_ready(i)), 32'(!m_busy[i]));
        chk($sformatf("mon_busy_n%0d", nper(i)), 32'(get_busy(i)), 32'(m_busy[i]));
        chk($sformatf("mon_done_n%0d", nper(i)), 32'(get_done(i)), 32'(m_done[i]));
        chk($sformatf("mon_p_n%0d", nper(i)), 32'(get_p(i)), 32'(m_p[i]));
      end
    end
  end

  // Starts a frame from a negedge; returns mid-bit samples and the cycle (k+t) DONE was seen
  task automatic run_frame(input int i, input logic [7:0] w, input bit poke,
                           output logic [10:0] bits, output int done_at);
    int n;
    n       = nper(i);
    bits    = '0;
    done_at = -1;
    set_in(i, 1'b1, w);
    for (int t = 1; t <= 60 && done_at < 0; t++) begin
      @(negedge clk);
      if (t == 1) set_in(i, 1'b0, w);
      if (poke && t == 15) set_in(i, 1'b1, 8'hFF);
      if (poke && t == 16) set_in(i, 1'b0, 8'hFF);
      if (t <= 11 * n && ((t - 1) % n) == n / 2) bits[(t - 1) / n] = get_tx(i);
      if (get_done(i)) done_at = t;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits, b0, b1;
    int          da, da2, cnt;
    logic [7:0]  w;
    vec_t        vecs [4];

    vecs[0] = '{w: 8'h01, p: 1'b0};
    vecs[1] = '{w: 8'h07, p: 1'b0};
    vecs[2] = '{w: 8'hA5, p: 1'b1};
    vecs[3] = '{w: 8'hFF, p: 1'b1};

    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx", 32'(get_tx(i)), 32'd1);
      chk("rst_ready", 32'(get_ready(i)), 32'd1);
      chk("rst_busy", 32'(get_busy(i)), 32'd0);
      chk("rst_done", 32'(get_done(i)), 32'd0);
      chk("rst_p", 32'(get_p(i)), 32'd0);
    end
    mon_en = 1'b1;

    // Word 0x00 at N=4
    run_frame(1, 8'h00, 1'b0, bits, da);
    chk("w00_frame", 32'(bits), 32'h600);
    chk("w00_done_at", 32'(da), 32'd45);
    chk("w00_p", 32'(get_p(1)), 32'd1);
    chk("w00_checker", 32'(checker_c(bits)), 32'd0);

    // Table of words at N=1
    for (int v = 0; v < 4; v++) begin
      run_frame(0, vecs[v].w, 1'b0, bits, da);
      chk("tbl_frame", 32'(bits), 32'(make_frame(vecs[v].w)));
      chk("tbl_pbit", 32'(bits[9]), 32'(vecs[v].p));
      chk("tbl_p", 32'(get_p(0)), 32'(vecs[v].p));
      chk("tbl_done_at", 32'(da), 32'd12);
      chk("tbl_checker", 32'(checker_c(bits)), 32'd0);
    end

    // LOAD held high: 0x3C then 0xC3 back to back
    set_in(1, 1'b1, 8'h3C);
    da = -1; da2 = -1; b0 = '0; b1 = '0;
    for (int t = 1; t <= 92; t++) begin
      @(negedge clk);
      if (t == 1) set_in(1, 1'b1, 8'hC3);
      if (t <= 44 && ((t - 1) % 4) == 2) b0[(t - 1) / 4] = get_tx(1);
      if (t >= 46 && t <= 89 && ((t - 46) % 4) == 2) b1[(t - 46) / 4] = get_tx(1);
      if (get_done(1) && da < 0) da = t;
      else if (get_done(1) && da2 < 0) da2 = t;
      if (t == 45) chk("b2b_gap_tx", 32'(get_tx(1)), 32'd1);
      if (t == 46) begin
        chk("b2b_start2_tx", 32'(get_tx(1)), 32'd0);
        set_in(1, 1'b0, 8'hC3);
      end
    end
    chk("b2b_done1", 32'(da), 32'd45);
    chk("b2b_frame1", 32'(b0), 32'(make_frame(8'h3C)));
    chk("b2b_frame2", 32'(b1), 32'(make_frame(8'hC3)));
    chk("b2b_done2", 32'(da2), 32'd90);

    // LOAD pulse with 0xFF mid-DATA is ignored
    run_frame(1, 8'h5B, 1'b1, bits, da);
    chk("poke_frame", 32'(bits), 32'(make_frame(8'h5B)));
    chk("poke_p", 32'(get_p(1)), 32'd0);
    chk("poke_done_at", 32'(da), 32'd45);

    // Reset in the 3rd data bit of 0x55
    @(negedge clk);
    set_in(1, 1'b1, 8'h55);
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      if (t == 1) set_in(1, 1'b0, 8'h55);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", 32'(get_tx(1)), 32'd1);
    chk("abort_ready", 32'(get_ready(1)), 32'd1);
    chk("abort_busy", 32'(get_busy(1)), 32'd0);
    chk("abort_p", 32'(get_p(1)), 32'd0);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (get_done(1)) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    run_frame(1, 8'h0F, 1'b0, bits, da);
    chk("after_abort_frame", 32'(bits), 32'(make_frame(8'h0F)));
    chk("after_abort_p", 32'(get_p(1)), 32'd1);
    chk("after_abort_done_at", 32'(da), 32'd45);

    // RST and LOAD together in IDLE
    @(negedge clk);
    set_in(1, 1'b1, 8'hAA);
    rst = 1'b1;
    @(negedge clk);
    set_in(1, 1'b0, 8'hAA);
    rst = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (get_tx(1) !== 1'b1 || get_busy(1) !== 1'b0) cnt++;
    end
    chk("rst_load_idle", 32'(cnt), 32'd0);

    // Parity error injection into the checker
    run_frame(1, 8'h80, 1'b0, bits, da);
    chk("inj_pbit", 32'(bits[9]), 32'd0);
    chk("inj_clean_c", 32'(checker_c(bits)), 32'd0);
    bits = bits ^ 11'h200;
    chk("inj_flip_c", 32'(checker_c(bits)), 32'd1);

    // Randomized words on both instances
    repeat (16) begin
      int i;
      i = int'($urandom_range(0, 1));
      w = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(i, w, 1'b0, bits, da);
      chk("rnd_frame", 32'(bits), 32'(make_frame(w)));
      chk("rnd_done_at", 32'(da), 32'(11 * nper(i) + 1));
      chk("rnd_checker", 32'(checker_c(bits)), 32'd0);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/odd_parity_serial_tx.md
# odd_parity_serial_tx

Serial frame transmitter that generates the odd parity bit for a parallel data word and shifts the word out on a single line. Each frame is start bit, data LSB-first, odd parity bit, stop bit. It is the sending end of the team's 8-bit odd parity link. Its deserialized output is consumed by `odd_parity_checker`, which must then report C=0.

## Interface
- `DATA_W`, default 8: data word width; frame carries DATA_W+3 bits.
- `CLKS_PER_BIT`, default 4: clock cycles each serial bit is held; legal range ≥1.

- `CLK`  input  1: single clock; all state updates on rising edge.
- `RST`  input  1: synchronous, active-high reset.
- `D`  input  DATA_W: data word; sampled only on an accepted LOAD.
- `LOAD`  input  1: request to transmit D.
- `READY`  output  1: block can accept LOAD this cycle.
- `TX`  output  1: serial line; idle level 1.
- `P`  output  1: registered odd parity of the last accepted word.
- `BUSY`  output  1: frame in progress.
- `DONE`  output  1: one-cycle pulse when a frame completes.

## Operation
- Reset values: TX=1, READY=1, BUSY=0, DONE=0, P=0, state IDLE, counters 0.
- Parity is P = ~(^D). The ones count of D plus P is always odd.
- Accept happens when LOAD=1 and READY=1 at a rising edge. On accept:
  - D is latched into a shift register.
  - P is latched.
  - State moves to START.
- LOAD with READY=0 is ignored. It has no effect on the frame, shift register or P.
- READY=1 only in IDLE. BUSY = ~READY.
- States (each non-IDLE state lasts exactly CLKS_PER_BIT cycles):
  - IDLE: TX=1. On accept, go to START.
  - START: TX=0. Then go to DATA.
  - DATA: TX = shift register bit 0. After each bit period, shift right and increment the bit counter. After DATA_W bits, go to PARITY.
  - PARITY: TX=P. Then go to STOP.
  - STOP: TX=1. Then go to IDLE and assert DONE.
- DONE is high for exactly the first IDLE cycle after STOP. It is never asserted after reset or after an aborted frame.
- TX is a registered output and glitch-free. It changes only at bit-period boundaries.
- Counter widths:
  - Cycle counter: $clog2(CLKS_PER_BIT), minimum 1 bit. Wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter: $clog2(DATA_W), minimum 1 bit. Wraps to 0 on leaving DATA.
- Back-to-back frames: LOAD held high is accepted in the DONE cycle. The next START begins one cycle later. The minimum idle gap between frames is therefore 1 cycle of TX=1 beyond the stop bit.
- RST mid-frame:
  - Next edge forces the reset values.
  - The partial frame is dropped.
  - The line returns to 1 immediately, with no stop-bit completion.
- RST and LOAD high in the same cycle: RST wins and nothing is accepted.

## Timing
- Let the accept edge be cycle k and N = CLKS_PER_BIT.
  - Start bit: TX=0 during cycles k+1 … k+N.
  - Data bit i (i=0…DATA_W-1): TX held during cycles k+1+(1+i)·N … k+(2+i)·N.
  - Parity: cycles k+1+(DATA_W+1)·N … k+(DATA_W+2)·N.
  - Stop: cycles k+1+(DATA_W+2)·N … k+(DATA_W+3)·N.
  - DONE=1 and READY=1 at cycle k+(DATA_W+3)·N+1.
- For defaults the frame lasts 44 cycles and DONE appears at k+45.
- P is valid from cycle k+1 and holds until the next accept or reset.
- N=1 is legal: one cycle per bit, frame of DATA_W+3 cycles.

## Test plan
- Word 0x00, N=4 → P=1; TX sampled mid-bit reads 0, 0000_0000, 1, 1. DONE at k+45. Loopback into `odd_parity_checker` gives C=0.
- Words 0x01, 0x07, 0xA5, 0xFF at N=1 → P = 0, 0, 1, 1 respectively. Serial data matches LSB-first order (0xA5 → 1,0,1,0,0,1,0,1). Checker C=0 for every word.
- LOAD held high continuously with words 0x3C then 0xC3 → second START begins exactly 1 cycle after the first frame's DONE. LOAD pulses while BUSY=1 (mid-DATA, with D=0xFF) are ignored: frame bits and P are unchanged.
- RST asserted in the 3rd data bit of a 0x55 frame → next cycle TX=1, READY=1, BUSY=0, P=0 and DONE never pulses. A fresh LOAD of 0x0F then produces a complete, correct frame with P=1.
- RST and LOAD asserted together in IDLE → no frame starts; TX stays 1 for 50 cycles.
- Error-injection loopback: capture the frame for 0x80 (P=0), flip the parity bit before feeding `odd_parity_checker` → C=1. The unflipped frame gives C=0.
